// File: rtl/tff_count_ctrl_if.sv
// Control-side handshake between a run requester and the T-FF counter sequencer.
// The requester drives start/stop/target; the sequencer reports status and the last sample.
interface tff_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] target;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] count_snap;

    modport master (
        output start, stop, target,
        input  busy, done, err, count_snap
    );

    modport slave (
        input  start, stop, target,
        output busy, done, err, count_snap
    );
endinterface

// File: rtl/tff_count_ctrl.sv
// Sequencer for an asynchronous T-flip-flop ripple counter: clears the chain, pulses T one
// count at a time, waits for the ripple to settle, and stops on a match with the latched target.
module tff_count_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    tff_count_ctrl_if.slave     bus,
    input  logic [WIDTH-1:0]    cnt_q,
    output logic                t_en,
    output logic                cnt_rst
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [WIDTH:0]   MAX_PULSES  = {1'b1, {WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_CHECK,
        S_PULSE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [WIDTH:0]     pulse_q, pulse_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [WIDTH-1:0]   snap_q, snap_d;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        pulse_d  = pulse_q;
        target_d = target_q;
        snap_d   = snap_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    target_d = bus.target;
                    pulse_d  = '0;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                settle_d = SETTLE_LOAD;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // Counter is preloaded with SETTLE-1, so WAIT lasts exactly SETTLE cycles.
                if (settle_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            S_CHECK: begin
                snap_d = cnt_q;
                if (cnt_q == target_q) begin
                    state_d = S_DONE;
                end else if (pulse_q == MAX_PULSES) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                pulse_d  = pulse_q + (WIDTH + 1)'(1);
                settle_d = SETTLE_LOAD;
                state_d  = S_WAIT;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // An abort leaves the previous sample visible rather than capturing a partial ripple.
        if (state_q != S_IDLE && bus.stop) begin
            state_d = S_IDLE;
            snap_d  = snap_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            pulse_q  <= '0;
            target_q <= '0;
            snap_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            pulse_q  <= pulse_d;
            target_q <= target_d;
            snap_q   <= snap_d;
        end
    end

    // The chain is also held clear while the controller itself sits in reset.
    assign cnt_rst        = rst || (state_q == S_CLEAR);
    assign t_en           = (state_q == S_PULSE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_ERR);
    assign bus.count_snap = snap_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Randomised bench for tff_count_ctrl with a behavioural ripple-chain model and a
// run-level reference that predicts timing, pulse counts and the final sample arithmetically.
module tb_tff_count_ctrl;

    localparam int W    = 4;
    localparam int S    = 2;
    localparam int STEP = S + 2;
    localparam int NMAX = 1 << W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tff_count_ctrl_if #(.WIDTH(W)) bus ();

    logic [W-1:0] cnt_q;
    logic [W-1:0] chain;
    logic         stuck;
    logic         t_en;
    logic         cnt_rst;

    tff_count_ctrl #(.WIDTH(W), .SETTLE(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cnt_q   (cnt_q),
        .t_en    (t_en),
        .cnt_rst (cnt_rst)
    );

    // Ripple chain: behaves as a plain binary counter once settled; optionally stuck at zero.
    always @(posedge clk) begin
        if (cnt_rst)   chain <= '0;
        else if (t_en) chain <= chain + 1'b1;
    end
    assign cnt_q = stuck ? '0 : chain;

    int           n_vec = 0;
    int           n_bad = 0;
    logic [W-1:0] snap_model = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One complete run; stop_at = edge at which stop is sampled (0 = never),
    // retrig_at = edge after which a second start is attempted (0 = never).
    task automatic run(input int tgt, input bit stk, input int stop_at, input int retrig_at);
        int  c, ptot, kmax, exp_pulses, end_e, e;
        int  done_e, err_e, n_done, n_err, n_ten, n_crst, last_ten, gap_bad;
        bit  aborted, ends_done;
        logic busy_at_stop;

        ends_done = !(stk && tgt != 0);
        ptot      = stk ? ((tgt == 0) ? 0 : NMAX) : tgt;
        c         = ends_done ? STEP * (tgt + 1) : STEP * (NMAX + 1);
        aborted   = (stop_at > 0) && (stop_at <= c);
        if (aborted) begin
            kmax       = (stop_at - 1) / STEP;
            exp_pulses = (kmax < ptot) ? kmax : ptot;
            if (kmax >= 1) snap_model = stk ? '0 : W'(kmax - 1);
            end_e = stop_at;
        end else begin
            exp_pulses = ptot;
            snap_model = stk ? '0 : W'(tgt);
            end_e = c;
        end

        done_e = -1; err_e = -1; n_done = 0; n_err = 0; n_ten = 0; n_crst = 0;
        last_ten = -1; gap_bad = 0; busy_at_stop = 1'b1;

        stuck      = stk;
        bus.target = W'(tgt);
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        e = 0;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        forever begin
            if (t_en) begin
                if (last_ten >= 0 && (e - last_ten) != STEP) gap_bad++;
                last_ten = e;
                n_ten++;
            end
            if (cnt_rst)  n_crst++;
            if (bus.done) begin n_done++; done_e = e; end
            if (bus.err)  begin n_err++;  err_e  = e; end
            if (aborted && e == stop_at) busy_at_stop = bus.busy;
            if (e >= end_e + 3 || e > 200) break;
            bus.stop   = (e + 1 == stop_at);
            bus.start  = (retrig_at > 0 && e == retrig_at);
            bus.target = bus.start ? W'(2) : W'($urandom);
            @(posedge clk);
            #1;
            e++;
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;

        chk("done_count", n_done, (!aborted && ends_done) ? 1 : 0);
        chk("err_count",  n_err,  (!aborted && !ends_done) ? 1 : 0);
        chk("done_edge",  done_e, (!aborted && ends_done) ? c : -1);
        chk("err_edge",   err_e,  (!aborted && !ends_done) ? c : -1);
        chk("t_en_pulses", n_ten, exp_pulses);
        chk("t_en_spacing_bad", gap_bad, 0);
        chk("cnt_rst_pulses", n_crst, 1);
        chk("count_snap", {28'd0, bus.count_snap}, {28'd0, snap_model});
        chk("busy_idle_end", {31'd0, bus.busy}, 32'd0);
        if (aborted) chk("busy_after_stop", {31'd0, busy_at_stop}, 32'd0);
        $display("run tgt=%0d stuck=%0d stop_at=%0d retrig=%0d pulses=%0d done_e=%0d err_e=%0d snap=%0d",
                 tgt, stk, stop_at, retrig_at, n_ten, done_e, err_e, bus.count_snap);
    endtask

    initial begin
        int tgt, c, sa;
        bit stk;

        rst = 1'b1; stuck = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.target = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    {31'd0, bus.busy}, 32'd0);
        chk("rst_done",    {31'd0, bus.done}, 32'd0);
        chk("rst_err",     {31'd0, bus.err},  32'd0);
        chk("rst_t_en",    {31'd0, t_en},     32'd0);
        chk("rst_cnt_rst", {31'd0, cnt_rst},  32'd1);
        chk("rst_snap",    {28'd0, bus.count_snap}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(3, 1'b0, 0, 0);
        run(0, 1'b0, 0, 0);
        run(7, 1'b1, 0, 0);
        run(9, 1'b0, 9, 0);

        bus.start = 1'b1; bus.stop = 1'b1; bus.target = W'(4);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("start_stop_busy", {31'd0, bus.busy}, 32'd0);
        end
        bus.start = 1'b0; bus.stop = 1'b0;
        $display("start+stop together in IDLE busy=%0d", bus.busy);

        run(6, 1'b0, 0, 5);

        // Reset held for two cycles while the run sits in WAIT.
        stuck = 1'b0; bus.target = W'(9); bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("midrst_busy",    {31'd0, bus.busy}, 32'd0);
            chk("midrst_t_en",    {31'd0, t_en},     32'd0);
            chk("midrst_done",    {31'd0, bus.done | bus.err}, 32'd0);
            chk("midrst_cnt_rst", {31'd0, cnt_rst},  32'd1);
            chk("midrst_snap",    {28'd0, bus.count_snap}, 32'd0);
        end
        rst = 1'b0;
        snap_model = '0;
        $display("mid-run reset applied busy=%0d snap=%0d", bus.busy, bus.count_snap);
        run(5, 1'b0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            tgt = int'($urandom_range(0, NMAX - 1));
            stk = ($urandom_range(0, 3) == 0);
            c   = (stk && tgt != 0) ? STEP * (NMAX + 1) : STEP * (tgt + 1);
            sa  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, c)) : 0;
            run(tgt, stk, sa, 0);
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
